// File: rtl/pipelined_tree_accumulator_if.sv
// Beat-in / result-out handshake bundle for the pipelined tree accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface pipelined_tree_accumulator_if #(
    parameter int P             = 8,
    parameter int INPUTS_AMOUNT = 8,
    parameter int OUT_W         = 32
);
    logic signed [P-1:0]     in_data_i [INPUTS_AMOUNT];
    logic                    in_last_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic signed [OUT_W-1:0] out_data_o;
    logic                    out_valid_o;
    logic                    out_ready_i;

    modport master (
        output in_data_i, in_last_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_last_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o
    );
endinterface

// File: rtl/pipelined_tree_accumulator.sv
// Registered binary adder tree over signed lanes, followed by a group accumulator
// that emits its running sum on the last-flagged beat. One global enable stalls everything.
module pipelined_tree_accumulator #(
    parameter int P             = 8,
    parameter int INPUTS_AMOUNT = 8,
    parameter int OUT_W         = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    pipelined_tree_accumulator_if.slave bus
);
    localparam int LEVELS = (INPUTS_AMOUNT > 1) ? $clog2(INPUTS_AMOUNT) : 0;
    localparam int NP     = 1 << LEVELS;

    logic en;
    assign en             = !bus.out_valid_o || bus.out_ready_i;
    assign bus.in_ready_o = en;

    // Lanes beyond INPUTS_AMOUNT are tied to zero so the tree is always a full power of two.
    logic signed [P-1:0] lane [NP];
    for (genvar i = 0; i < NP; i++) begin : g_pad
        if (i < INPUTS_AMOUNT) begin : g_real
            assign lane[i] = bus.in_data_i[i];
        end else begin : g_zero
            assign lane[i] = '0;
        end
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int W = P + k;
        localparam int M = NP >> k;

        logic signed [W-1:0] sum_q [M];
        logic                vld_q;
        logic                last_q;

        if (k == 0) begin : g_in
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q  <= 1'b0;
                    last_q <= 1'b0;
                    for (int j = 0; j < M; j++) sum_q[j] <= '0;
                end else if (en) begin
                    vld_q  <= bus.in_valid_i;
                    last_q <= bus.in_last_i;
                    for (int j = 0; j < M; j++) sum_q[j] <= lane[j];
                end
            end
        end else begin : g_add
            // Each operand is sign-extended by one bit so the pair sum cannot overflow.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q  <= 1'b0;
                    last_q <= 1'b0;
                    for (int j = 0; j < M; j++) sum_q[j] <= '0;
                end else if (en) begin
                    vld_q  <= g_lvl[k-1].vld_q;
                    last_q <= g_lvl[k-1].last_q;
                    for (int j = 0; j < M; j++) begin
                        sum_q[j] <= {g_lvl[k-1].sum_q[2*j][W-2],   g_lvl[k-1].sum_q[2*j]}
                                  + {g_lvl[k-1].sum_q[2*j+1][W-2], g_lvl[k-1].sum_q[2*j+1]};
                    end
                end
            end
        end
    end

    logic signed [OUT_W-1:0] tree_sum;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] acc_plus;

    assign tree_sum = OUT_W'(g_lvl[LEVELS].sum_q[0]);
    assign acc_plus = acc_q + tree_sum;

    // en high means the output slot is free or being drained this cycle, so it may be reloaded or cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q           <= '0;
            bus.out_data_o  <= '0;
            bus.out_valid_o <= 1'b0;
        end else if (en) begin
            if (g_lvl[LEVELS].vld_q) begin
                if (g_lvl[LEVELS].last_q) begin
                    bus.out_data_o  <= acc_plus;
                    bus.out_valid_o <= 1'b1;
                    acc_q           <= '0;
                end else begin
                    acc_q           <= acc_plus;
                    bus.out_valid_o <= 1'b0;
                end
            end else begin
                bus.out_valid_o <= 1'b0;
            end
        end
    end
endmodule
